pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed ID/EX stage register: a generic pipeline stage register with valid/ready handshake, a 2-entry skid buffer, and synchronous flush.
- Sits between any two pipeline stages (IF/ID, ID/EX, EX/MEM). Decouples the upstream ready path from the downstream ready path so no combinational ready chain spans stages.
- Replaces the per-stage stall/flush vector decoding with local handshakes plus one flush input.

---
 rtl/pipe_stage_skid_pkg.sv | 20 ++
 rtl/pipe_stage_skid_dff_lrc.sv | 20 ++
 rtl/pipe_stage_skid.sv | 116 +++++++++++
 tb/tb_pipe_stage_skid.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and widths for pipe_stage_skid and its payload registers.
package pipe_stage_skid_pkg;

  localparam int unsigned PIPE_ST_BUS = 2;

  typedef enum logic [PIPE_ST_BUS-1:0] {
    PIPE_ST_EMPTY = 2'b00,
    PIPE_ST_BUSY  = 2'b01,
    PIPE_ST_FULL  = 2'b10
  } pipe_st_e;

  localparam int unsigned REG_BUS_WIDTH      = 32;
  localparam int unsigned REG_ADDR_BUS_WIDTH = 5;
  localparam int unsigned DEC_INFO_BUS_WIDTH = 32;
  localparam int unsigned CSR_ADDR_BUS_WIDTH = 12;

  localparam int unsigned ID_EX_DATA_W = 3*REG_BUS_WIDTH + REG_BUS_WIDTH + REG_ADDR_BUS_WIDTH + 1
                                       + DEC_INFO_BUS_WIDTH + CSR_ADDR_BUS_WIDTH + 1;

endpackage

// File: rtl/pipe_stage_skid_dff_lrc.sv
// dff_lrc: payload register with synchronous clear (priority) and load enable.
module dff_lrc #(
  parameter int unsigned        W       = 8,
  parameter logic [W-1:0]       RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      o_q <= RST_VAL;
    else if (i_clr)  o_q <= RST_VAL;
    else if (i_load) o_q <= i_d;
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry skid and flush.
// Optional perf counters enabled by defining PIPE_PERF_CNT_EN.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int unsigned       DATA_W        = 128,
  parameter logic [DATA_W-1:0] RST_VAL       = '0,
  parameter int unsigned       SKID_EN_DEPTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush_i
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_bubble_cnt
`endif
);

  pipe_st_e          r_state, w_next;
  logic              w_acc, w_take;
  logic              w_main_load, w_main_sel_skid, w_skid_load;
  logic [DATA_W-1:0] w_main_d, w_main_q, w_skid_q;

  // With the skid, in_ready is a pure function of the state register.
  assign in_ready  = (SKID_EN_DEPTH != 0) ? (r_state != PIPE_ST_FULL)
                                          : ((r_state == PIPE_ST_EMPTY) | out_ready);
  assign out_valid = (r_state != PIPE_ST_EMPTY);
  assign out_data  = w_main_q;
  assign w_acc     = in_valid & in_ready;
  assign w_take    = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PIPE_ST_EMPTY;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush_i) begin
      w_next = PIPE_ST_EMPTY;
    end else begin
      unique case (r_state)
        PIPE_ST_EMPTY: if (w_acc) w_next = PIPE_ST_BUSY;
        PIPE_ST_BUSY: begin
          if (w_acc && !w_take && (SKID_EN_DEPTH != 0)) w_next = PIPE_ST_FULL;
          else if (!w_acc && w_take)                    w_next = PIPE_ST_EMPTY;
        end
        PIPE_ST_FULL: if (w_take) w_next = PIPE_ST_BUSY;
        default:      w_next = PIPE_ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    w_main_load     = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_load     = 1'b0;
    unique case (r_state)
      PIPE_ST_EMPTY: w_main_load = w_acc;
      PIPE_ST_BUSY: begin
        w_main_load = w_acc & out_ready;
        w_skid_load = w_acc & ~out_ready & (SKID_EN_DEPTH != 0);
      end
      PIPE_ST_FULL: begin
        w_main_load     = out_ready;
        w_main_sel_skid = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : in_data;

  dff_lrc #(.W(DATA_W), .RST_VAL(RST_VAL)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush_i),
    .i_load(w_main_load),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  dff_lrc #(.W(DATA_W), .RST_VAL(RST_VAL)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (flush_i),
    .i_load(w_skid_load),
    .i_d   (in_data),
    .o_q   (w_skid_q)
  );

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (out_valid && !out_ready) r_stall_cnt  <= r_stall_cnt + 32'd1;
      if (!out_valid)              r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt  = r_stall_cnt;
  assign perf_bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid and plain instances checked against a queue-style model.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        flush = 1'b0;

  logic        s_ir, s_ov, p_ir, p_ov;
  logic [31:0] s_od, p_od;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] s_stall, s_bubble, p_stall, p_bubble;
`endif

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .RST_VAL(32'h0), .SKID_EN_DEPTH(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_ir), .in_data(in_data),
    .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od), .flush_i(flush)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_cnt(s_stall), .perf_bubble_cnt(s_bubble)
`endif
  );

  pipe_stage_skid #(.DATA_W(32), .RST_VAL(32'h0), .SKID_EN_DEPTH(0)) u_plain (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(p_ir), .in_data(in_data),
    .out_valid(p_ov), .out_ready(out_ready), .out_data(p_od), .flush_i(flush)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_cnt(p_stall), .perf_bubble_cnt(p_bubble)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: k=0 skid instance (capacity 2), k=1 plain instance (capacity 1, pass-through ready).
  logic [31:0] m_q[2][2];
  int unsigned m_n[2];
  logic [31:0] m_last[2];
  logic [31:0] m_stall[2];
  logic [31:0] m_bubble[2];

  function automatic logic exp_ready(input int unsigned k);
    if (k == 0) return m_n[0] < 2;
    return (m_n[1] == 0) || out_ready;
  endfunction

  function automatic logic [31:0] exp_data(input int unsigned k);
    return (m_n[k] > 0) ? m_q[k][0] : m_last[k];
  endfunction

  task automatic model_reset();
    for (int unsigned k = 0; k < 2; k++) begin
      m_n[k] = 0; m_last[k] = '0; m_stall[k] = '0; m_bubble[k] = '0;
    end
  endtask

  task automatic model_step();
    for (int unsigned k = 0; k < 2; k++) begin
      logic take, acc;
      if (m_n[k] == 0)    m_bubble[k] = m_bubble[k] + 1;
      else if (!out_ready) m_stall[k] = m_stall[k] + 1;
      take = (m_n[k] > 0) && out_ready;
      acc  = in_valid && exp_ready(k);
      if (flush) begin
        m_n[k] = 0; m_last[k] = '0;
      end else begin
        if (take) begin
          m_last[k] = m_q[k][0]; m_q[k][0] = m_q[k][1]; m_n[k]--;
        end
        if (acc) begin
          m_q[k][m_n[k]] = in_data; m_n[k]++;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".s_valid"}, 64'(s_ov), 64'(m_n[0] > 0));
    chk({tag, ".s_data"},  64'(s_od), 64'(exp_data(0)));
    chk({tag, ".s_ready"}, 64'(s_ir), 64'(exp_ready(0)));
    chk({tag, ".p_valid"}, 64'(p_ov), 64'(m_n[1] > 0));
    chk({tag, ".p_data"},  64'(p_od), 64'(exp_data(1)));
    chk({tag, ".p_ready"}, 64'(p_ir), 64'(exp_ready(1)));
`ifdef PIPE_PERF_CNT_EN
    chk({tag, ".s_stall"},  64'(s_stall),  64'(m_stall[0]));
    chk({tag, ".s_bubble"}, 64'(s_bubble), 64'(m_bubble[0]));
    chk({tag, ".p_stall"},  64'(p_stall),  64'(m_stall[1]));
    chk({tag, ".p_bubble"}, 64'(p_bubble), 64'(m_bubble[1]));
`endif
  endtask

  task automatic cycle(input string tag, input logic iv, input logic [31:0] d,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
    #1;
    check_all(tag);
    @(posedge clk);
    model_step();
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Perf: 5 empty cycles, then hold one item for 3 stalled cycles.
    for (int i = 0; i < 5; i++) cycle("idle", 1'b0, '0, 1'b0, 1'b0);
    cycle("pf_push", 1'b1, 32'h55, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("pf_stall", 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) cycle("pf_drain", 1'b0, '0, 1'b1, 1'b0);

    // Streaming 1..4 with downstream always ready.
    for (int i = 1; i <= 4; i++) cycle("stream", 1'b1, 32'(i), 1'b1, 1'b0);
    cycle("stream_end", 1'b0, '0, 1'b1, 1'b0);

    // Backpressure: A, B fill the skid, C is held upstream, then drain.
    cycle("bp_a", 1'b1, 32'hA, 1'b0, 1'b0);
    cycle("bp_b", 1'b1, 32'hB, 1'b0, 1'b0);
    cycle("bp_c_held", 1'b1, 32'hC, 1'b0, 1'b0);
    cycle("bp_c", 1'b1, 32'hC, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("bp_drain", 1'b0, '0, 1'b1, 1'b0);

    // Flush while FULL with 0xDEAD offered.
    cycle("fl_a", 1'b1, 32'h11, 1'b0, 1'b0);
    cycle("fl_b", 1'b1, 32'h22, 1'b0, 1'b0);
    cycle("fl_hit", 1'b1, 32'hDEAD, 1'b0, 1'b1);
    cycle("fl_after", 1'b0, '0, 1'b1, 1'b0);
    chk("fl_s_ready", 64'(s_ir), 64'd1);
    chk("fl_s_data_rst", 64'(s_od), 64'd0);

    // out_ready toggling with continuous input.
    for (int i = 0; i < 8; i++) cycle("toggle", 1'b1, 32'h100 + 32'(i), 1'((i % 2) == 0), 1'b0);
    for (int i = 0; i < 4; i++) cycle("toggle_drain", 1'b0, '0, 1'b1, 1'b0);

    // Async reset mid-stream while FULL.
    cycle("rs_a", 1'b1, 32'h77, 1'b0, 1'b0);
    cycle("rs_b", 1'b1, 32'h88, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_s_valid", 64'(s_ov), 64'd0);
    chk("rst_s_data",  64'(s_od), 64'd0);
    chk("rst_p_valid", 64'(p_ov), 64'd0);
    chk("rst_p_data",  64'(p_od), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_s_ready", 64'(s_ir), 64'd1);
    @(posedge clk);
    model_step();

    // Random traffic with occasional flush.
    for (int i = 0; i < 600; i++)
      cycle("rand", 1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 31) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
